// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op, state and LOHI direct-write encodings for the HI/LO multiply/divide unit
package hilo_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_e;
  localparam int LOHI_WRITE_OPT_WIDTH = 2;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_NONE = 2'd0;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_LO = 2'd1;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_HI = 2'd2;
  function automatic logic is_div(op_e o);
    return o == OP_DIV || o == OP_DIVU;
  endfunction
endpackage

// File: rtl/hilo_divider.sv
// hilo_divider: sequential restoring divider, one quotient bit per cycle, signed/unsigned
module hilo_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cancel,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);
  localparam int SW = $clog2(W + 2);
  logic run, sgn_r, ge, neg_q, neg_r;
  logic [SW-1:0] step;
  logic [W-1:0] a_r, b_r, quo, rem, bm, diff;
  logic [W:0] sh;
  always_comb begin
    sh = {rem, quo[W-1]};
    ge = sh >= {1'b0, bm};
    diff = sh[W-1:0] - bm;
    neg_q = sgn_r && (a_r[W-1] ^ b_r[W-1]);
    neg_r = sgn_r && a_r[W-1];
    done = run && step == SW'(W + 1);
    // a zero divisor bypasses the sign fix: all-ones quotient, dividend as remainder
    q = b_r == '0 ? '1 : neg_q ? -quo : quo;
    r = b_r == '0 ? a_r : neg_r ? -rem : rem;
  end
  // step 0 conditions operands, steps 1..W iterate, step W+1 presents the sign-fixed result
  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      run <= 1'b0;
      step <= '0;
      sgn_r <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      quo <= '0;
      rem <= '0;
      bm <= '0;
    end else if (start && !run) begin
      run <= 1'b1;
      step <= '0;
      sgn_r <= sgn;
      a_r <= a;
      b_r <= b;
    end else if (run) begin
      step <= step + 1'b1;
      if (step == '0) begin
        quo <= sgn_r && a_r[W-1] ? -a_r : a_r;
        bm <= sgn_r && b_r[W-1] ? -b_r : b_r;
        rem <= '0;
      end else if (step <= SW'(W)) begin
        quo <= {quo[W-2:0], ge};
        rem <= ge ? diff : sh[W-1:0];
      end else begin
        run <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO multiply/divide unit with direct register writes; divider built only when HILO_MULDIV_DIV_EN is defined
module hilo_muldiv import hilo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int MUL_LATENCY = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  op_e                             op,
  input  logic [WIDTH-1:0]                opr1,
  input  logic [WIDTH-1:0]                opr2,
  input  logic [LOHI_WRITE_OPT_WIDTH-1:0] write_opt,
  input  logic [WIDTH-1:0]                write_data,
  output logic [2*WIDTH-1:0]              result,
  output logic                            busy,
  output logic                            done
);
  state_e state, nxt;
  logic [3:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, div_q, div_r;
  logic [2*WIDTH-1:0] prod;
  logic mul_sgn, nd_pend, wr, accept, mul_fin, div_fin, div_done;
`ifdef HILO_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
  hilo_divider #(.W(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(accept && is_div(op)),
    .cancel(wr),
    .sgn(op == OP_DIV),
    .a(opr1),
    .b(opr2),
    .done(div_done),
    .q(div_q),
    .r(div_r)
  );
`else
  localparam bit DIV_EN = 1'b0;
  assign div_done = 1'b0;
  assign div_q = '0;
  assign div_r = '0;
`endif
  // sign-extending both operands to 2*WIDTH lets one multiplier serve MULT and MULTU
  assign prod = {{WIDTH{mul_sgn & a_r[WIDTH-1]}}, a_r} * {{WIDTH{mul_sgn & b_r[WIDTH-1]}}, b_r};
  always_ff @(posedge clk) state <= rst ? ST_IDLE : nxt;
  always_comb nxt = wr || mul_fin || div_fin ? ST_IDLE :
                    state == ST_IDLE && accept ? (is_div(op) ? (DIV_EN ? ST_DIV : ST_IDLE) : ST_MUL) : state;
  always_comb begin
    busy = state != ST_IDLE;
    wr = write_opt != LOHI_WRITE_NONE;
    accept = start && !busy && !wr;
    mul_fin = state == ST_MUL && cnt == '0;
    div_fin = state == ST_DIV && div_done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      mul_sgn <= 1'b0;
      nd_pend <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      nd_pend <= accept && is_div(op) && !DIV_EN;
      done <= nd_pend || (!wr && (mul_fin || div_fin));
      if (accept) begin
        a_r <= opr1;
        b_r <= opr2;
        mul_sgn <= op == OP_MULT;
        cnt <= 4'(MUL_LATENCY - 1);
      end else if (state == ST_MUL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (write_opt == LOHI_WRITE_LO) result[WIDTH-1:0] <= write_data;
      else if (write_opt == LOHI_WRITE_HI) result[2*WIDTH-1:WIDTH] <= write_data;
      else if (mul_fin) result <= prod;
      else if (div_fin) result <= {div_r, div_q};
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench for hilo_muldiv (divide checks follow HILO_MULDIV_DIV_EN)
module tb_hilo_muldiv;
  import hilo_pkg::*;
  localparam int W = 32;
  localparam int L = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  op_e op = OP_MULT;
  logic [W-1:0] opr1 = '0, opr2 = '0, write_data = '0;
  logic [LOHI_WRITE_OPT_WIDTH-1:0] write_opt = LOHI_WRITE_NONE;
  logic [2*W-1:0] result;
  logic busy, done;
  int errors = 0, checks = 0, done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_res = '0;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  hilo_muldiv #(.WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .write_opt(write_opt), .write_data(write_data), .result(result), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input op_e o, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (o == OP_MULT) return longint'($signed(a)) * longint'($signed(b));
    if (o == OP_MULTU) return longint'(a) * longint'(b);
`ifdef HILO_MULDIV_DIV_EN
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == OP_DIVU) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {32'(r), 32'(q)};
`else
    q = 0;
    r = 0;
    return {32'(r), 32'(q)};
`endif
  endfunction

  task automatic run_op(input string tag, input op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input logic exp_busy);
    int lat;
    logic [63:0] e;
    exp_q.push_back(exp);
    start = 1'b1; op = o; opr1 = a; opr2 = b;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'(exp_busy));
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check({tag, " result"}, result, e);
    model_res = e;
    tick();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " hold"}, result, e);
  endtask

  task automatic reset_mid(input string tag, input op_e o);
    int d0;
    start = 1'b1; op = o; opr1 = 32'd600; opr2 = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0 = done_cnt;
    model_res = '0;
    check({tag, " result"}, result, 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    repeat (40) tick();
    check({tag, " no done"}, 64'(done_cnt - d0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [31:0] a, b;
    op_e o;
    rst = 1'b1; start = 1'b1; write_opt = LOHI_WRITE_LO; write_data = 32'hDEAD;
    tick();
    tick();
    check("reset result", result, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0; start = 1'b0; write_opt = LOHI_WRITE_NONE;
    tick();
    check("post-reset busy", 64'(busy), 64'd0);

    run_op("mult neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, L, 1'b1);
    run_op("multu", OP_MULTU, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1, L, 1'b1);
    run_op("mult minmin", OP_MULT, 32'h80000000, 32'h80000000, model(OP_MULT, 32'h80000000, 32'h80000000), L, 1'b1);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      o = $urandom_range(0, 1) ? OP_MULT : OP_MULTU;
      run_op("mul rand", o, a, b, model(o, a, b), L, 1'b1);
    end

    write_opt = LOHI_WRITE_LO; write_data = 32'h11112222;
    tick();
    write_opt = LOHI_WRITE_NONE;
    model_res = {model_res[63:32], 32'h11112222};
    check("write lo", result, model_res);
    write_opt = LOHI_WRITE_HI; write_data = 32'h33334444;
    tick();
    write_opt = LOHI_WRITE_NONE;
    model_res = {32'h33334444, model_res[31:0]};
    check("write hi", result, model_res);

    d0 = done_cnt;
    start = 1'b1; op = OP_MULTU; opr1 = 32'd3; opr2 = 32'd4;
    tick();
    opr1 = 32'd7;
    tick();
    start = 1'b0;
    tick();
    write_opt = LOHI_WRITE_LO; write_data = 32'h1234;
    tick();
    write_opt = LOHI_WRITE_NONE;
    model_res = {model_res[63:32], 32'h1234};
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel result", result, model_res);
    repeat (15) tick();
    check("cancel no done", 64'(done_cnt - d0), 64'd0);
    check("cancel held", result, model_res);

    d0 = done_cnt;
    start = 1'b1; op = OP_MULTU; opr1 = 32'd9; opr2 = 32'd9;
    write_opt = LOHI_WRITE_HI; write_data = 32'hABCD;
    tick();
    start = 1'b0; write_opt = LOHI_WRITE_NONE;
    model_res = {32'hABCD, model_res[31:0]};
    check("start+write busy", 64'(busy), 64'd0);
    check("start+write result", result, model_res);
    repeat (12) tick();
    check("start+write no done", 64'(done_cnt - d0), 64'd0);

    reset_mid("rst mid mul", OP_MULT);
    run_op("mult after rst", OP_MULT, 32'd6, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFD6, L, 1'b1);

`ifdef HILO_MULDIV_DIV_EN
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'hE}, W + 2, 1'b1);
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, W + 2, 1'b1);
    run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, W + 2, 1'b1);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, W + 2, 1'b1);
    run_op("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, W + 2, 1'b1);
    run_op("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, W + 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      o = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
      run_op("div rand", o, a, b, model(o, a, b), W + 2, 1'b1);
    end
    reset_mid("rst mid div", OP_DIV);
`else
    run_op("div off", OP_DIV, 32'd100, 32'd7, model_res, 1, 1'b0);
    run_op("divu off", OP_DIVU, 32'd5, 32'd0, model_res, 1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter WIDTH, 32: operand width; result is 2*WIDTH bits (hi = upper half, lo = lower half).
REQ-002 Parameter MUL_LATENCY, 8: cycles from accepted multiply start to done; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  2  operation: MULT, MULTU, DIV, DIVU (encodings in package).
REQ-007 opr1 / opr2  input  WIDTH each  multiplicand/dividend and multiplier/divisor; captured on accept.
REQ-008 write_opt  input  LOHI_WRITE_OPT_WIDTH  direct-write select: none, LOHI_WRITE_LO, LOHI_WRITE_HI.
REQ-009 write_data  input  WIDTH  data for direct write.
REQ-010 result  output  2*WIDTH  hi:lo register.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  single-cycle pulse in the cycle result takes the new value.

Function
REQ-013 States: IDLE, MUL, DIV; IDLE->MUL or IDLE->DIV on accepted start; MUL/DIV->IDLE on completion or cancel.
REQ-014 Start is accepted when start=1, busy=0, write_opt=none; operands and op are registered that edge; busy rises next cycle.
REQ-015 start while busy=1 is ignored; no queueing.
REQ-016 MULT/MULTU: result = full 2*WIDTH product, signed or unsigned; result and done update exactly MUL_LATENCY cycles after accept edge.
REQ-017 DIV/DIVU: lo = quotient, hi = remainder; completion exactly WIDTH+2 cycles after accept edge (1 operand-conditioning cycle, WIDTH iteration cycles, 1 sign-fix cycle).
REQ-018 Signed divide truncates toward zero; quotient sign = sign(opr1) xor sign(opr2); remainder sign = sign(opr1).
REQ-019 Divide by zero: lo = all ones, hi = opr1 (both signed and unsigned); latency unchanged.
REQ-020 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-021 Direct write in IDLE updates the selected half on that edge; the other half is held.
REQ-022 Direct write while busy cancels the operation: return to IDLE, no done pulse, write applied, other half holds its pre-operation value.
REQ-023 Start and write in the same IDLE cycle: write applied, start ignored.
REQ-024 result holds its value between operations; done is 0 except the completion cycle.

Reset
REQ-025 On rst=1: state IDLE, result=0, busy=0, done=0, internal counters/operands cleared; rst overrides start and write_opt.
REQ-026 rst mid-operation aborts it; no done pulse follows.

Configuration
REQ-027 Macro HILO_MULDIV_DIV_EN: defined -> divide path and DIV state built per REQ-017..020.
REQ-028 Undefined -> no divider logic; accepted DIV/DIVU leaves result unchanged, busy stays 0, done pulses once on the cycle after accept.

Structure
REQ-029 Shared package hilo_pkg holds op encodings, state encoding and LOHI write-option constants (existing lohi definitions reused, not duplicated).
REQ-030 Divider is sub-module hilo_divider (sequential restoring, one quotient bit per cycle, start/done handshake), instantiated only under HILO_MULDIV_DIV_EN.
REQ-031 Multiplier is a behavioural product plus MUL_LATENCY-deep delay/counter within hilo_muldiv.

Verification (WIDTH=32, MUL_LATENCY=8)
REQ-032 MULT opr1=0xFFFFFFFD, opr2=5 -> done 8 cycles after accept, result=0xFFFFFFFF_FFFFFFF1; MULTU same operands -> 0x00000004_FFFFFFF1.
REQ-033 DIVU 100/7 -> done 34 cycles after accept, hi=2, lo=0xE; DIV 0xFFFFFFF9/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-034 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 Start MULTU 3*4, write LO=0x1234 at cycle 3 -> no done, busy=0 next cycle, result lo=0x1234, hi unchanged; second start during busy ignored.
REQ-036 rst asserted mid-DIV -> next cycle result=0, busy=0, no done; build without HILO_MULDIV_DIV_EN -> DIV leaves result unchanged, done one cycle after accept.
